// File: rtl/mac_vdp_lanes.sv
// ============================================================================
//  Module   : mac_vdp_lanes
//  Purpose  : L-lane pipelined vector dot-product MAC with valid/ready flow.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mac_vdp_lanes #(
  parameter int N      = 8,
  parameter int K      = 4,
  parameter int L      = 2,
  parameter int SIGNED = 1,
  localparam int W     = 2*N + $clog2(K)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [L*N-1:0] g_input,
  input  logic [L*N-1:0] e_input,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   o
);

  localparam int BEATS = K / L;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = 2*N;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  logic [CW-1:0] r_cnt;
  logic          r_pvalid;
  logic          r_plast;
  logic [PW-1:0] r_prod [L];
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_o;
  logic          r_ovalid;

  logic [PW-1:0] w_prod [L];
  logic [W-1:0]  w_ext;
  logic [W-1:0]  w_sum;
  logic [W-1:0]  w_acc_next;
  logic          w_accept;
  logic          w_last_beat;
  logic          w_load;

  // Operands are widened to 2N first so one multiplier form serves both modes.
  generate
    for (genvar i = 0; i < L; i++) begin : g_lane
      logic [PW-1:0] w_ga;
      logic [PW-1:0] w_ea;
      if (SIGNED != 0) begin : g_sext
        assign w_ga = {{N{g_input[i*N+N-1]}}, g_input[i*N +: N]};
        assign w_ea = {{N{e_input[i*N+N-1]}}, e_input[i*N +: N]};
      end else begin : g_zext
        assign w_ga = {{N{1'b0}}, g_input[i*N +: N]};
        assign w_ea = {{N{1'b0}}, e_input[i*N +: N]};
      end
      assign w_prod[i] = w_ga * w_ea;
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    w_ext = '0;
    for (int i = 0; i < L; i++) begin
      w_ext          = {W{(SIGNED != 0) & r_prod[i][PW-1]}};
      w_ext[PW-1:0]  = r_prod[i];
      w_sum          = w_sum + w_ext;
    end
  end

  assign w_acc_next  = r_acc + w_sum;
  // One bubble after each last beat keeps a finished sum from colliding with a new vector.
  assign in_ready    = !(r_pvalid && r_plast) && !(r_ovalid && !out_ready);
  assign w_accept    = in_valid && in_ready && !flush;
  assign w_last_beat = (r_cnt == LAST_CNT);
  assign w_load      = r_pvalid && r_plast && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_pvalid <= 1'b0;
      r_plast  <= 1'b0;
      r_acc    <= '0;
      r_o      <= '0;
      r_ovalid <= 1'b0;
      for (int i = 0; i < L; i++) r_prod[i] <= '0;
    end else begin
      if (flush) begin
        r_cnt    <= '0;
        r_pvalid <= 1'b0;
        r_plast  <= 1'b0;
        r_acc    <= '0;
      end else begin
        r_pvalid <= w_accept;
        if (w_accept) begin
          for (int i = 0; i < L; i++) r_prod[i] <= w_prod[i];
          r_plast <= w_last_beat;
          r_cnt   <= w_last_beat ? '0 : r_cnt + CW'(1);
        end
        if (r_pvalid) begin
          r_acc <= r_plast ? '0 : w_acc_next;
        end
      end

      // A fresh result may replace one being handed off on the same edge.
      if (w_load) begin
        r_o      <= w_acc_next;
        r_ovalid <= 1'b1;
      end else if (r_ovalid && out_ready) begin
        r_ovalid <= 1'b0;
      end
    end
  end

  assign out_valid = r_ovalid;
  assign o         = r_o;

endmodule

`default_nettype wire

// File: tb/tb_mac_vdp_lanes.sv
// ============================================================================
//  Module   : tb_mac_vdp_lanes
//  Purpose  : Signed and unsigned instances driven in lockstep against a model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mac_vdp_lanes;

  localparam int N = 8;
  localparam int K = 4;
  localparam int L = 2;
  localparam int W = 2*N + $clog2(K);

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           in_valid;
  logic           out_ready;
  logic [L*N-1:0] g_input;
  logic [L*N-1:0] e_input;
  logic           in_ready_s, in_ready_u;
  logic           out_valid_s, out_valid_u;
  logic [W-1:0]   o_s, o_u;

  always #5 clk = ~clk;

  mac_vdp_lanes #(.N(N), .K(K), .L(L), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .g_input(g_input), .e_input(e_input), .out_valid(out_valid_s),
    .out_ready(out_ready), .o(o_s)
  );

  mac_vdp_lanes #(.N(N), .K(K), .L(L), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_u),
    .g_input(g_input), .e_input(e_input), .out_valid(out_valid_u),
    .out_ready(out_ready), .o(o_u)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: collect elements until K are present, then take the plain dot product.
  int     qg[$];
  int     qe[$];
  logic   m_pend = 1'b0;
  longint m_pend_s, m_pend_u;
  logic   m_ovalid = 1'b0;
  longint m_o_s = 0, m_o_u = 0;

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  always @(negedge clk) begin
    logic exp_ready;
    if (rst) begin
      qg.delete(); qe.delete();
      m_pend = 1'b0; m_ovalid = 1'b0; m_o_s = 0; m_o_u = 0;
    end
    exp_ready = !m_pend && !(m_ovalid && !out_ready);
    check("in_ready_s", in_ready_s, exp_ready);
    check("in_ready_u", in_ready_u, exp_ready);
    check("out_valid_s", out_valid_s, m_ovalid);
    check("out_valid_u", out_valid_u, m_ovalid);
    if (m_ovalid || rst) begin
      check("o_s", $signed(o_s), m_o_s);
      check("o_u", o_u, m_o_u);
    end
    if (!rst) begin
      if (m_pend && !flush) begin
        m_ovalid = 1'b1; m_o_s = m_pend_s; m_o_u = m_pend_u;
      end else if (m_ovalid && out_ready) begin
        m_ovalid = 1'b0;
      end
      if (flush) begin
        qg.delete(); qe.delete(); m_pend = 1'b0;
      end else begin
        m_pend = 1'b0;
        if (in_valid && exp_ready) begin
          for (int i = 0; i < L; i++) begin
            qg.push_back(int'(g_input[i*N +: N]));
            qe.push_back(int'(e_input[i*N +: N]));
          end
          if (qg.size() == K) begin
            m_pend_s = 0; m_pend_u = 0;
            for (int i = 0; i < K; i++) begin
              m_pend_s += longint'(sx(qg[i]) * sx(qe[i]));
              m_pend_u += longint'(qg[i] * qe[i]);
            end
            m_pend = 1'b1;
            qg.delete(); qe.delete();
          end
        end
      end
    end
  end

  task automatic send_beat(input int g0, input int g1, input int e0, input int e1);
    logic done = 1'b0;
    g_input  = {8'(g1), 8'(g0)};
    e_input  = {8'(e1), 8'(e0)};
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready_s && !flush) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("beat_accept_timeout", 0, 1);
  endtask

  task automatic send_vec(input int g0, input int g1, input int g2, input int g3,
                          input int e0, input int e1, input int e2, input int e3);
    send_beat(g0, g1, e0, e1);
    send_beat(g2, g3, e2, e3);
  endtask

  task automatic wait_result(input string name, input longint exp_s, input longint exp_u);
    logic found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (out_valid_s) found = 1'b1;
    end
    if (!found) check({name, "_timeout"}, 0, 1);
    else begin
      check({name, "_s"}, $signed(o_s), exp_s);
      check({name, "_u"}, o_u, exp_u);
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] rnd8();
    case ($urandom_range(0, 4))
      0:       return 8'h80;
      1:       return 8'h7f;
      2:       return 8'hff;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    g_input = '0; e_input = '0;
    #7;
    check("reset_in_ready", in_ready_s, 1);
    check("reset_out_valid", out_valid_s, 0);
    check("reset_o", o_s, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic vector with latency and bubble checks
    send_vec(23, -23, 5, -128, 99, 99, -7, -128);
    @(negedge clk);
    check("bubble_in_ready", in_ready_s, 0);
    check("bubble_out_valid", out_valid_s, 0);
    @(negedge clk);
    check("lat_out_valid", out_valid_s, 1);
    check("lat_o_s", $signed(o_s), 16349);
    check("lat_o_u", o_u, 42973);
    check("post_bubble_in_ready", in_ready_s, 1);
    @(posedge clk); #1;

    send_vec(-128, -128, -128, -128, -128, -128, -128, -128);
    wait_result("neg_sq", 65536, 65536);
    send_vec(-128, -128, -128, -128, 127, 127, 127, 127);
    wait_result("mixed", -65024, 65024);
    send_vec(255, 255, 255, 255, 255, 255, 255, 255);
    wait_result("all_ff", 4, 260100);

    // Backpressure with a beat waiting at the input
    out_ready = 1'b0;
    send_vec(2, 2, 2, 2, 3, 3, 3, 3);
    wait_result("bp_first", 24, 24);
    g_input = {8'd2, 8'd1}; e_input = {8'd3, 8'd4}; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid_s, 1);
      check("bp_hold_o", o_s, 24);
      check("bp_in_ready", in_ready_s, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_vec(1, 2, 3, 4, 4, 3, 2, 1);
    wait_result("after_bp", 20, 20);

    // Gapped beats
    send_beat(23, -23, 99, 99);
    repeat (3) @(posedge clk);
    #1;
    send_beat(5, -128, -7, -128);
    wait_result("gapped", 16349, 42973);

    // Flush mid-vector
    send_beat(9, 9, 9, 9);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    send_vec(1, 1, 1, 1, 2, 2, 2, 2);
    wait_result("after_flush", 8, 8);

    // Asynchronous reset mid-vector
    send_beat(9, 9, 9, 9);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_o", o_s, 0);
    check("async_rst_valid", out_valid_s, 0);
    check("async_rst_in_ready", in_ready_s, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    send_vec(1, 1, 1, 1, 2, 2, 2, 2);
    wait_result("after_rst", 8, 8);

    // Randomised traffic, model-checked every cycle
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      g_input   = {rnd8(), rnd8()};
      e_input   = {rnd8(), rnd8()};
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0) && !m_pend;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_vdp_lanes.md
# mac_vdp_lanes

Pipelined, multi-lane vector dot-product MAC for the vdp benchmark family. It consumes two K-element vectors as K/L beats of L element pairs each, and accumulates the L lane products per beat. It emits one full-width dot product per vector on a valid/ready output. It generalises the single-cycle N×N MAC in three ways: lane count, vector depth, signed/unsigned mode, plus flow control.

## Interface
- N, 8, element bit-width (≥2)
- K, 4, vector dimension; must be a multiple of L
- L, 2, lanes (element pairs per beat)
- SIGNED, 1, 1 = two's-complement operands/result, 0 = unsigned
- W (localparam) = 2N + $clog2(K), result width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous abort of the vector in progress
- in_valid  in  1  beat present on g_input/e_input
- in_ready  out  1  block can accept a beat
- g_input  in  L*N  lane i = bits [i*N +: N], element index beat*L+i
- e_input  in  L*N  same packing as g_input
- out_valid  out  1  o holds a completed dot product
- out_ready  in  1  downstream accepts o
- o  out  W  dot product, sign-extended per SIGNED

## Operation
- Beat accepted on a rising edge with in_valid && in_ready. Beat counter cnt counts 0..K/L-1 and wraps to 0 after the last beat. The last beat is the one with cnt == K/L-1.
- Stage P (products): on acceptance, register L products of width 2N (signed or unsigned per SIGNED), p_valid <= 1, and p_last <= (cnt == K/L-1). With no acceptance, p_valid <= 0.
- Stage A (accumulate): when p_valid, s = sum of the L products extended to W bits.
  - If p_last: o <= acc + s, out_valid <= 1, acc <= 0.
  - Otherwise: acc <= acc + s.
- The first beat of every vector starts from acc = 0; no explicit clear is needed between vectors.
- W is sized to be overflow-free:
  - Signed worst case: K·(−2^(N−1))² = K·2^(2N−2), which fits in W bits signed.
  - Unsigned worst case: K·(2^N−1)², which fits in W bits.
- in_ready = !(p_valid && p_last) && !(out_valid && !out_ready). This gives one bubble after each last beat and stalls input while a result is unaccepted.
- Output handshake: the result is transferred on an edge with out_valid && out_ready, which sets out_valid <= 0.
  - If stage A loads a new result on the same edge, out_valid stays 1 and o takes the new value.
  - o is held stable while out_valid && !out_ready.
- flush (highest priority below rst) clears cnt, p_valid, p_last and acc. It does not touch o or out_valid, and any beat presented in that cycle is discarded.
- rst clears cnt, p_valid, p_last, acc, o (0) and out_valid (0) immediately. in_ready is therefore 1 during and after reset.

## Timing
- Latency: last beat accepted at edge E, products registered at E, out_valid = 1 and o valid after edge E+1.
- Throughput: K/L+1 cycles per vector with out_ready held high. With L = K, one vector every 2 cycles.
- in_valid may drop between beats; cnt and acc hold across the gaps.
- Deasserting rst mid-vector discards the partial vector, and the next beat is treated as element 0.
- flush together with in_valid: the beat is not accepted and cnt = 0 on the next cycle.
- out_ready asserted with out_valid = 0 has no effect.

## Test plan
- N=8, K=4, L=2, SIGNED=1: send g=[23,−23,5,−128], e=[99,99,−7,−128] → o = 16349 (18-bit) with out_valid one cycle after the second beat's acceptance; in_ready low for exactly one cycle after the last beat.
- Extremes, signed: all elements −128 on both inputs → o = 65536. Mixed signs, g all −128 and e all 127 → o = −65024. There must be no wraparound.
- SIGNED=0 instance, same N/K/L: all elements 255 → o = 260100.
- Backpressure: hold out_ready = 0 for 5 cycles after a result appears → o and out_valid are stable and in_ready = 0. Then raise out_ready and stream the next vector g=[1,2,3,4], e=[4,3,2,1] → o = 20.
- Gapped input: the same vector as the first scenario with in_valid low for 3 cycles between beats → o = 16349.
- Abort:
  - Accept one beat, pulse flush, then send g=[1,1,1,1], e=[2,2,2,2] → o = 8.
  - Repeat with rst asserted asynchronously mid-vector → o = 0 and out_valid = 0 immediately, and the next vector yields 8.
